// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the countdown controller: FSM state type and
// default parameter values for count width and prescaler period.
package countdown_pkg;

    localparam int N_DEF        = 6;
    localparam int PRESCALE_DEF = 50_000_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

endpackage

// File: rtl/countdown_controller_tick_gen.sv
// tick_gen
// Prescaler that divides clk down to the count-step rate. The phase counter
// runs 0..PRESCALE-1 while enabled and wraps; tick is high during the cycle
// in which the counter sits at its terminal value with en asserted, so the
// consumer acts on the same edge that wraps the counter. When en is low the
// phase is held, which is what lets a pause resume mid-period.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears the phase
//   clr   - synchronous clear, wins over en
//   en    - advance the phase this cycle
//   tick  - terminal-count indication (combinational, qualified by en/clr)
module tick_gen
    import countdown_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] phase;

    assign tick = en && !clr && (phase == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_controller.sv
// countdown_controller
// Sequencing controller for the down-counter / seven-segment display path.
// Owns the count and reload registers and walks IDLE -> RUN -> DONE, with a
// PAUSE state that freezes both the count and the prescaler phase.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high
//   start_btn  - start/resume request, debounced level, acted on at rise
//   pause_btn  - pause/resume toggle, debounced level, acted on at rise
//   load_en    - capture load_value into count and reload (IDLE/PAUSE/DONE)
//   load_value - preset value
//   count      - current count (low nibble -> display1, bits 5:4 -> display2)
//   running    - high while in RUN
//   done       - high while in DONE
//   tick       - one-cycle pulse on every decrement
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_btn,
    input  logic         pause_btn,
    input  logic         load_en,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count,
    output logic         running,
    output logic         done,
    output logic         tick
);

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] reload;
    logic [N-1:0] reload_next;
    logic [N-1:0] count_next;
    logic         tick_next;

    logic start_prev;
    logic pause_prev;
    logic start_rise;
    logic pause_rise;

    logic presc_clr;
    logic presc_en;
    logic step;

    assign start_rise = start_btn & ~start_prev;
    assign pause_rise = pause_btn & ~pause_prev;

    // The prescaler sits at zero whenever we are outside RUN/PAUSE, so every
    // entry into RUN from IDLE or DONE starts a full period. The cycle that
    // takes a pause rise must not advance it, otherwise resuming would lose
    // one cycle of the period.
    assign presc_clr = (state == S_IDLE) || (state == S_DONE);
    assign presc_en  = (state == S_RUN) && !pause_rise;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            start_prev <= start_btn;
            pause_prev <= pause_btn;
        end
    end

    // Within a cycle load_en outranks a start rise, which outranks a pause
    // rise. The count-is-zero guard in RUN keeps the counter from ever
    // rolling over, even though RUN is never entered with a zero count.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        tick_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_en) begin
                    count_next  = load_value;
                    reload_next = load_value;
                end else if (start_rise) begin
                    state_next = (count != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (pause_rise) begin
                    state_next = S_PAUSE;
                end else if (step && (count != '0)) begin
                    tick_next  = 1'b1;
                    count_next = count - 1'b1;
                    if (count == ONE) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (load_en) begin
                    count_next  = load_value;
                    reload_next = load_value;
                    state_next  = S_IDLE;
                end else if (start_rise || pause_rise) begin
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (load_en) begin
                    count_next  = load_value;
                    reload_next = load_value;
                    state_next  = S_IDLE;
                end else if (start_rise && (reload != '0)) begin
                    count_next = reload;
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // running/done are registered from the next state so they line up with
    // the edge that performs the transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= {N{1'b1}};
            reload  <= {N{1'b1}};
            running <= 1'b0;
            done    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            reload  <= reload_next;
            running <= (state_next == S_RUN);
            done    <= (state_next == S_DONE);
            tick    <= tick_next;
        end
    end

endmodule
